// File: rtl/rom_port_arbiter_if.sv
// Bundle of requester-side (f_*, d_*) and genrom-side (rom_*) signals for rom_port_arbiter.
// The slave modport is the arbiter's view; master is the view of the core and genrom around it.
interface rom_port_arbiter_if #(
    parameter int AW    = 4,
    parameter int EXTRA = 4,
    parameter int DW    = 8
);
    localparam int WW = (2**EXTRA) * DW;

    logic             f_req,   d_req;
    logic [AW:0]      f_addr,  d_addr;
    logic [EXTRA-1:0] f_extra, d_extra;
    logic [AW:0]      f_lower, d_lower;
    logic [AW:0]      f_upper, d_upper;
    logic             f_gnt,   d_gnt;
    logic             f_valid, d_valid;
    logic [WW-1:0]    f_data,  d_data;
    logic             f_error, d_error;

    logic [AW:0]      rom_addr;
    logic [EXTRA-1:0] rom_extra;
    logic [AW:0]      rom_lower_bound;
    logic [AW:0]      rom_upper_bound;
    logic [WW-1:0]    rom_data;
    logic             rom_error;

    modport slave (
        input  f_req, f_addr, f_extra, f_lower, f_upper,
        input  d_req, d_addr, d_extra, d_lower, d_upper,
        output f_gnt, f_valid, f_data, f_error,
        output d_gnt, d_valid, d_data, d_error,
        output rom_addr, rom_extra, rom_lower_bound, rom_upper_bound,
        input  rom_data, rom_error
    );

    modport master (
        output f_req, f_addr, f_extra, f_lower, f_upper,
        output d_req, d_addr, d_extra, d_lower, d_upper,
        input  f_gnt, f_valid, f_data, f_error,
        input  d_gnt, d_valid, d_data, d_error,
        input  rom_addr, rom_extra, rom_lower_bound, rom_upper_bound,
        output rom_data, rom_error
    );
endinterface

// File: rtl/rom_port_arbiter.sv
// Shares one genrom read port between instruction fetch (f) and data load (d), 3 cycles/access.
// Define ROM_ARB_RR_EN for round-robin tie-breaking; default is fixed priority to f.
module rom_port_arbiter #(
    parameter int AW    = 4,
    parameter int EXTRA = 4,
    parameter int DW    = 8
) (
    input  logic                clk,
    input  logic                reset,
    rom_port_arbiter_if.slave   bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] CAPT = 2'd2;

    logic [1:0] state;
    logic       owner_f;   // 1: current access belongs to f
    logic       last_f;    // 1: most recent grant went to f
    logic       win_f;

`ifdef ROM_ARB_RR_EN
    // On a tie the side not granted last wins; a lone requester always wins.
    always_comb begin
        win_f = bus.f_req;
        if (bus.f_req && bus.d_req)
            win_f = !last_f;
    end
`else
    always_comb begin
        win_f = bus.f_req;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            owner_f             <= 1'b0;
            last_f              <= 1'b0;
            bus.rom_addr        <= '0;
            bus.rom_extra       <= '0;
            bus.rom_lower_bound <= '0;
            bus.rom_upper_bound <= '1;
            bus.f_gnt           <= 1'b0;
            bus.d_gnt           <= 1'b0;
            bus.f_valid         <= 1'b0;
            bus.d_valid         <= 1'b0;
            bus.f_data          <= '0;
            bus.d_data          <= '0;
            bus.f_error         <= 1'b0;
            bus.d_error         <= 1'b0;
        end else begin
            bus.f_gnt   <= 1'b0;
            bus.d_gnt   <= 1'b0;
            bus.f_valid <= 1'b0;
            bus.d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.f_req || bus.d_req) begin
                        bus.rom_addr        <= win_f ? bus.f_addr  : bus.d_addr;
                        bus.rom_extra       <= win_f ? bus.f_extra : bus.d_extra;
                        bus.rom_lower_bound <= win_f ? bus.f_lower : bus.d_lower;
                        bus.rom_upper_bound <= win_f ? bus.f_upper : bus.d_upper;
                        owner_f   <= win_f;
                        last_f    <= win_f;
                        bus.f_gnt <= win_f;
                        bus.d_gnt <= !win_f;
                        state     <= WAIT;
                    end
                end
                // genrom samples rom_* on this edge; its data appears for CAPT.
                WAIT: state <= CAPT;
                CAPT: begin
                    if (owner_f) begin
                        bus.f_data  <= bus.rom_data;
                        bus.f_error <= bus.rom_error;
                        bus.f_valid <= 1'b1;
                    end else begin
                        bus.d_data  <= bus.rom_data;
                        bus.d_error <= bus.rom_error;
                        bus.d_valid <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
